// File: rtl/cache_controller_pkg.sv
// rtl/cache_controller_pkg.sv - shared geometry constants and FSM encoding for cache_controller
// Purpose: fixes the cache geometry (64 sets, 2 ways, one 32-bit word per line),
//          the data region base address and the controller state encoding.
// Ports:   none (package).
package cache_controller_pkg;

  localparam int NUM_SETS = 64;
  localparam int NUM_WAYS = 2;
  localparam int INDEX_W  = 6;
  localparam int TAG_W    = 11;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 32;

  localparam logic [ADDR_W-1:0] DATA_BASE = 32'd1024;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_READ_MISS  = 2'd1,
    ST_WRITE_THRU = 2'd2
  } state_t;

  // Byte offset of an address inside the data region.
  function automatic logic [ADDR_W-1:0] region_offset(input logic [ADDR_W-1:0] addr);
    return addr - DATA_BASE;
  endfunction

endpackage

// File: rtl/cache_set_array.sv
// rtl/cache_set_array.sv - registered valid/tag/data/LRU storage for the 2-way cache
// Purpose: holds both ways of every set plus one LRU bit per set (LRU = way to evict next).
// Ports:
//   clk, rst            - clock, synchronous active-high reset (clears valid and LRU bits)
//   index               - set selected for both the combinational read and the writes
//   valid0/1, tag0/1,
//   data0/1, lru        - combinational read of the selected set
//   fill_en, fill_way,
//   fill_tag, fill_data - write one way of the selected set (marks it valid)
//   lru_en, lru_value   - update the LRU bit of the selected set
module cache_set_array
  import cache_controller_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] index,
  output logic               valid0,
  output logic               valid1,
  output logic [TAG_W-1:0]   tag0,
  output logic [TAG_W-1:0]   tag1,
  output logic [DATA_W-1:0]  data0,
  output logic [DATA_W-1:0]  data1,
  output logic               lru,
  input  logic               fill_en,
  input  logic               fill_way,
  input  logic [TAG_W-1:0]   fill_tag,
  input  logic [DATA_W-1:0]  fill_data,
  input  logic               lru_en,
  input  logic               lru_value
);

  logic [NUM_SETS-1:0] valid0_q;
  logic [NUM_SETS-1:0] valid1_q;
  logic [NUM_SETS-1:0] lru_q;
  logic [TAG_W-1:0]    tag0_q  [NUM_SETS];
  logic [TAG_W-1:0]    tag1_q  [NUM_SETS];
  logic [DATA_W-1:0]   data0_q [NUM_SETS];
  logic [DATA_W-1:0]   data1_q [NUM_SETS];

  // Control bits: cleared by reset so every line reads as invalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid0_q <= '0;
      valid1_q <= '0;
      lru_q    <= '0;
    end else begin
      if (fill_en) begin
        if (fill_way) valid1_q[index] <= 1'b1;
        else          valid0_q[index] <= 1'b1;
      end
      if (lru_en) lru_q[index] <= lru_value;
    end
  end

  // Payload needs no reset: it is never used while the valid bit is clear.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      if (fill_way) begin
        tag1_q[index]  <= fill_tag;
        data1_q[index] <= fill_data;
      end else begin
        tag0_q[index]  <= fill_tag;
        data0_q[index] <= fill_data;
      end
    end
  end

  assign valid0 = valid0_q[index];
  assign valid1 = valid1_q[index];
  assign tag0   = tag0_q[index];
  assign tag1   = tag1_q[index];
  assign data0  = data0_q[index];
  assign data1  = data1_q[index];
  assign lru    = lru_q[index];

endmodule

// File: rtl/cache_controller.sv
// rtl/cache_controller.sv - 2-way set-associative write-through read cache in front of the SRAM controller
// Purpose: serves read hits in the same cycle, forwards misses and all writes to the
//          SRAM controller and stalls the pipeline through ready until each access ends.
//          Define CACHE_BYPASS_EN to compile out the arrays: every access then goes to SRAM.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   wrEn, rdEn               - MEM-stage store / load request (store has priority)
//   address, writeData       - byte address (data region starts at 1024), store data
//   readData, ready          - load data (valid with ready & rdEn), 0 stalls the pipeline
//   sramWrEn, sramRdEn       - requests to the SRAM controller
//   sramAddress, sramWriteData - pass-through of address / writeData
//   sramReadData, sramReady  - SRAM controller response
module cache_controller
  import cache_controller_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wrEn,
  input  logic              rdEn,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] writeData,
  output logic [DATA_W-1:0] readData,
  output logic              ready,
  output logic              sramWrEn,
  output logic              sramRdEn,
  output logic [ADDR_W-1:0] sramAddress,
  output logic [DATA_W-1:0] sramWriteData,
  input  logic [DATA_W-1:0] sramReadData,
  input  logic              sramReady
);

  state_t state_q, state_d;
  logic   req_seen_q;

  logic [ADDR_W-1:0]  off;
  logic [INDEX_W-1:0] index;
  logic [TAG_W-1:0]   tag;

  logic               hit;
  logic               hit_way;
  logic               victim;
  logic [DATA_W-1:0]  hit_data;

  logic               fill_en;
  logic               fill_way;
  logic [DATA_W-1:0]  fill_data;
  logic               lru_en;
  logic               lru_value;
  logic               done;

  assign off   = region_offset(address);
  assign index = off[7:2];
  assign tag   = off[18:8];

  logic unused_off;
  assign unused_off = ^{off[ADDR_W-1:19], off[1:0]};

  assign sramAddress   = address;
  assign sramWriteData = writeData;
  assign sramRdEn      = (state_q == ST_READ_MISS);
  assign sramWrEn      = (state_q == ST_WRITE_THRU);

`ifdef CACHE_BYPASS_EN
  assign hit      = 1'b0;
  assign hit_way  = 1'b0;
  assign victim   = 1'b0;
  assign hit_data = '0;

  logic unused_bypass;
  assign unused_bypass = ^{fill_en, fill_way, fill_data, lru_en, lru_value, tag, index, hit_data, victim};
`else
  logic              valid0, valid1, lru;
  logic [TAG_W-1:0]  tag0, tag1;
  logic [DATA_W-1:0] data0, data1;
  logic              hit0, hit1;

  cache_set_array u_set_array (
    .clk       (clk),
    .rst       (rst),
    .index     (index),
    .valid0    (valid0),
    .valid1    (valid1),
    .tag0      (tag0),
    .tag1      (tag1),
    .data0     (data0),
    .data1     (data1),
    .lru       (lru),
    .fill_en   (fill_en),
    .fill_way  (fill_way),
    .fill_tag  (tag),
    .fill_data (fill_data),
    .lru_en    (lru_en),
    .lru_value (lru_value)
  );

  assign hit0     = valid0 && (tag0 == tag);
  assign hit1     = valid1 && (tag1 == tag);
  assign hit      = hit0 || hit1;
  // Way 0 wins if both ways ever match.
  assign hit_way  = !hit0 && hit1;
  assign hit_data = hit_way ? data1 : data0;
  // Fill an empty way before evicting anything.
  assign victim   = !valid0 ? 1'b0 : (!valid1 ? 1'b1 : lru);
`endif

  // The SRAM controller idles with ready high, so its ready only counts as a
  // completion once our request has been on the bus for at least one cycle.
  assign done = req_seen_q && sramReady;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      req_seen_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_seen_q <= (state_q != ST_IDLE) && (state_d != ST_IDLE);
    end
  end

  always_comb begin
    state_d   = state_q;
    ready     = 1'b0;
    readData  = sramReadData;
    fill_en   = 1'b0;
    fill_way  = 1'b0;
    fill_data = sramReadData;
    lru_en    = 1'b0;
    lru_value = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (wrEn) begin
          state_d = ST_WRITE_THRU;
        end else if (rdEn) begin
          if (hit) begin
            ready     = 1'b1;
            readData  = hit_data;
            lru_en    = 1'b1;
            lru_value = !hit_way;
          end else begin
            state_d = ST_READ_MISS;
          end
        end else begin
          ready = 1'b1;
        end
      end

      ST_READ_MISS: begin
        if (done) begin
          ready     = 1'b1;
          fill_en   = 1'b1;
          fill_way  = victim;
          fill_data = sramReadData;
          lru_en    = 1'b1;
          lru_value = !victim;
          state_d   = ST_IDLE;
        end
      end

      ST_WRITE_THRU: begin
        if (done) begin
          ready   = 1'b1;
          state_d = ST_IDLE;
          // Write-no-allocate: only a line already present is refreshed.
          if (hit) begin
            fill_en   = 1'b1;
            fill_way  = hit_way;
            fill_data = writeData;
            lru_en    = 1'b1;
            lru_value = !hit_way;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_controller.sv
// tb/tb_cache_controller.sv - scoreboard bench for cache_controller with a fixed-latency SRAM model
module tb_cache_controller;

  localparam int LAT       = 3;
  localparam int MISS_WAIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        wrEn, rdEn;
  logic [31:0] address, writeData;
  logic [31:0] readData;
  logic        ready;
  logic        sramWrEn, sramRdEn;
  logic [31:0] sramAddress, sramWriteData;
  logic [31:0] sramReadData;
  logic        sramReady;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        is_write;
    logic        exp_hit;
    logic [31:0] data;
    logic [31:0] addr;
  } exp_t;

  exp_t sb_q[$];

  cache_controller dut (
    .clk           (clk),
    .rst           (rst),
    .wrEn          (wrEn),
    .rdEn          (rdEn),
    .address       (address),
    .writeData     (writeData),
    .readData      (readData),
    .ready         (ready),
    .sramWrEn      (sramWrEn),
    .sramRdEn      (sramRdEn),
    .sramAddress   (sramAddress),
    .sramWriteData (sramWriteData),
    .sramReadData  (sramReadData),
    .sramReady     (sramReady)
  );

  always #5 clk = ~clk;

  // SRAM controller model: ready high while idle, pulses ready LAT cycles into a request.
  logic [31:0] sram_mem [logic [31:0]];
  int          lat_cnt;

  always @(posedge clk) begin
    if (rst || !(sramRdEn || sramWrEn)) begin
      lat_cnt   <= 0;
      sramReady <= 1'b1;
    end else begin
      lat_cnt   <= lat_cnt + 1;
      sramReady <= (lat_cnt + 1 == LAT);
      if ((lat_cnt + 1 == LAT) && sramWrEn) sram_mem[sramAddress] = sramWriteData;
    end
    sramReadData <= sram_mem.exists(sramAddress) ? sram_mem[sramAddress]
                                                 : {16'hC0DE, sramAddress[15:0]};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: tracks each access and checks it against the scoreboard on completion.
  int   waited = 0;
  logic saw_rd = 1'b0;
  logic saw_wr = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      waited = 0; saw_rd = 1'b0; saw_wr = 1'b0;
    end else if (rdEn || wrEn) begin
      if (sramRdEn) saw_rd = 1'b1;
      if (sramWrEn) saw_wr = 1'b1;
      if (!ready) begin
        waited++;
      end else begin
        if (sb_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_completion: addr %h completed with no expected access", address);
        end else begin
          e = sb_q.pop_front();
          chk("sram_address", sramAddress, e.addr);
          if (e.is_write) begin
            chk("write_wait_cycles", waited, MISS_WAIT);
            chk("write_saw_sramWrEn", {31'd0, saw_wr}, 32'd1);
            chk("write_saw_sramRdEn", {31'd0, saw_rd}, 32'd0);
          end else begin
            chk("read_data", readData, e.data);
            chk("read_wait_cycles", waited, e.exp_hit ? 0 : MISS_WAIT);
            chk("read_saw_sramRdEn", {31'd0, saw_rd}, e.exp_hit ? 32'd0 : 32'd1);
            chk("read_saw_sramWrEn", {31'd0, saw_wr}, 32'd0);
          end
        end
        waited = 0; saw_rd = 1'b0; saw_wr = 1'b0;
      end
    end
  end

  // Driver: called #1 after a posedge; holds the request until ready, then idles one cycle.
  task automatic access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_data, input logic exp_hit);
    exp_t e;
    bit   got;
    e.is_write = wr; e.exp_hit = exp_hit; e.data = exp_data; e.addr = addr;
    sb_q.push_back(e);
    wrEn = wr; rdEn = !wr; address = addr; writeData = wdata;
    got = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready) begin got = 1; break; end
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL timeout addr=%h: no ready within 40 cycles, required ready=1", addr);
      sb_q.delete();
    end
    @(posedge clk); #1;
    wrEn = 1'b0; rdEn = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; wrEn = 1'b0; rdEn = 1'b0; address = 32'd0; writeData = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("reset_ready", {31'd0, ready}, 32'd1);
    chk("reset_sramRdEn", {31'd0, sramRdEn}, 32'd0);
    chk("reset_sramWrEn", {31'd0, sramWrEn}, 32'd0);
    address = 32'h0000_1234; writeData = 32'hA5A5_5A5A;
    #1;
    chk("passthru_address", sramAddress, 32'h0000_1234);
    chk("passthru_wdata", sramWriteData, 32'hA5A5_5A5A);
    @(posedge clk); #1;

    // Set 0: 1024 tag0, 1280 tag1, 1536 tag2, 2048 tag4.
    access(1'b0, 32'd1024, 32'd0, 32'hC0DE_0400, 1'b0);  // fill way0, lru=1
    access(1'b0, 32'd1024, 32'd0, 32'hC0DE_0400, 1'b1);  // hit, lru=1
    access(1'b0, 32'd1280, 32'd0, 32'hC0DE_0500, 1'b0);  // fill way1, lru=0
    access(1'b0, 32'd1536, 32'd0, 32'hC0DE_0600, 1'b0);  // evict tag0 from way0, lru=1
    access(1'b0, 32'd1280, 32'd0, 32'hC0DE_0500, 1'b1);  // hit way1, lru=0
    access(1'b0, 32'd1024, 32'd0, 32'hC0DE_0400, 1'b0);  // miss, evicts tag2, lru=1
    access(1'b1, 32'd1280, 32'hDEAD_BEEF, 32'd0, 1'b0);  // write hit way1, lru=0
    access(1'b0, 32'd1280, 32'd0, 32'hDEAD_BEEF, 1'b1);  // hit with new data
    access(1'b1, 32'd2048, 32'h1234_5678, 32'd0, 1'b0);  // write miss, no allocation
    access(1'b0, 32'd2048, 32'd0, 32'h1234_5678, 1'b0);  // miss, fills way0
    access(1'b0, 32'd1280, 32'd0, 32'hDEAD_BEEF, 1'b1);  // way1 untouched

    // Reset during a read miss.
    rdEn = 1'b1; address = 32'd1536;
    repeat (2) @(posedge clk); #1;
    chk("midmiss_sramRdEn", {31'd0, sramRdEn}, 32'd1);
    rst = 1'b1; rdEn = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_sramRdEn", {31'd0, sramRdEn}, 32'd0);
    chk("abort_sramWrEn", {31'd0, sramWrEn}, 32'd0);
    chk("abort_ready", {31'd0, ready}, 32'd1);
    @(posedge clk); #1;

    access(1'b0, 32'd1024, 32'd0, 32'hC0DE_0400, 1'b0);  // lines invalidated
    access(1'b0, 32'd1024, 32'd0, 32'hC0DE_0400, 1'b1);

    chk("scoreboard_drained", sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
